pipe_stage_reg: RTL and testbench

//  Generic parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the MIPS/FP pipeline.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline inter-stage registers.
package pipe_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;

  localparam int IF_ID_DATA_W  = 32;
  localparam int ID_EX_DATA_W  = 128;
  localparam int EX_MEM_DATA_W = 96;
  localparam int MEM_WB_DATA_W = 72;

  typedef enum logic [1:0] {
    MAIN_HOLD      = 2'd0,
    MAIN_LOAD_IN   = 2'd1,
    MAIN_LOAD_SKID = 2'd2,
    MAIN_CLEAR     = 2'd3
  } main_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline register: payload + PC + valid bit.
// Clearing restores the bubble values so the slot can drive outputs directly.
module pipe_slot #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] CLR_DATA = '0,
  parameter logic [PC_W-1:0]   CLR_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]   d_pc,
  output logic              valid,
  output logic [DATA_W-1:0] q_data,
  output logic [PC_W-1:0]   q_pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      q_data <= CLR_DATA;
      q_pc   <= CLR_PC;
    end else if (clear) begin
      valid  <= 1'b0;
      q_data <= CLR_DATA;
      q_pc   <= CLR_PC;
    end else if (load) begin
      valid  <= 1'b1;
      q_data <= d_data;
      q_pc   <= d_pc;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. All outputs come straight from flops.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = IF_ID_DATA_W,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
  parameter int                STALL_CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [PC_W-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [PC_W-1:0]     out_pc,
  output logic [STALL_CW-1:0] stall_cnt
);

  localparam logic [PC_W-1:0] CLR_PC = PC_W'(RESET_PC);

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [PC_W-1:0]   skid_pc;

  logic              accept;
  logic              deliver;
  main_op_e          main_op;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic [DATA_W-1:0] main_d_data;
  logic [PC_W-1:0]   main_d_pc;

  // skid_valid is a flop, so in_ready has no combinational input dependency
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign deliver   = main_valid & out_ready;

  always_comb begin
    main_op    = MAIN_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_op    = MAIN_CLEAR;
      skid_clear = 1'b1;
    end else if (!main_valid) begin
      if (accept) main_op = MAIN_LOAD_IN;
    end else if (deliver) begin
      if (skid_valid) begin
        main_op    = MAIN_LOAD_SKID;
        skid_clear = 1'b1;
      end else if (accept) begin
        main_op = MAIN_LOAD_IN;
      end else begin
        main_op = MAIN_CLEAR;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  always_comb begin
    main_load   = (main_op == MAIN_LOAD_IN) || (main_op == MAIN_LOAD_SKID);
    main_clear  = (main_op == MAIN_CLEAR);
    main_d_data = (main_op == MAIN_LOAD_SKID) ? skid_data : in_data;
    main_d_pc   = (main_op == MAIN_LOAD_SKID) ? skid_pc   : in_pc;
  end

  pipe_slot #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .CLR_DATA (NOP_WORD),
    .CLR_PC   (CLR_PC)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_pc   (main_d_pc),
    .valid  (main_valid),
    .q_data (out_data),
    .q_pc   (out_pc)
  );

  pipe_slot #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .CLR_DATA (NOP_WORD),
    .CLR_PC   (CLR_PC)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (in_data),
    .d_pc   (in_pc),
    .valid  (skid_valid),
    .q_data (skid_data),
    .q_pc   (skid_pc)
  );

  // flush deliberately leaves the counter alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg against a queue-based model.
module tb_pipe_stage_reg;

  localparam int          STALL_CW  = 4;
  localparam logic [31:0] NOP       = 32'h0;
  localparam int          STALL_MAX = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic [31:0]         in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_data;
  logic [31:0]         out_pc;
  logic [STALL_CW-1:0] stall_cnt;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   m_stall;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (32),
    .PC_W     (32),
    .NOP_WORD (NOP),
    .STALL_CW (STALL_CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pc    (out_pc),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk({tag, ".out_data"}, out_data, q[0].d);
      chk({tag, ".out_pc"},   out_pc,   q[0].pc);
    end else begin
      chk({tag, ".out_data"}, out_data, NOP);
      chk({tag, ".out_pc"},   out_pc,   32'h0);
    end
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
  endtask

  // Advance one clock with the currently driven inputs and update the model:
  // the stage is a 2-deep FIFO whose in_ready reflects occupancy at the edge.
  task automatic tick(input string tag);
    bit acc, del;
    acc = in_valid && (q.size() < 2);
    del = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready && (m_stall < STALL_MAX)) m_stall++;
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back('{d: in_data, pc: in_pc});
    end
    check_model(tag);
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    q.delete();
    m_stall = 0;
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data",  out_data,       NOP);
    chk("rst.out_pc",    out_pc,         32'h0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h1);
  endtask

  task automatic rand_cycle(input string tag);
    in_valid  = ($urandom_range(99) < 70);
    out_ready = ($urandom_range(99) < 60);
    flush     = ($urandom_range(99) < 2);
    in_data   = $urandom;
    in_pc     = $urandom;
    tick(tag);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    q.delete();
    m_stall = 0;
    #12;
    reset = 1'b1;
    @(negedge clk);

    // 1: reset mid-run, asserted asynchronously between edges
    for (int i = 0; i < 20; i++) rand_cycle("pre_rst");
    in_valid  = 1'b1;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick("pre_rst_fill");
    tick("pre_rst_fill2");
    do_reset();
    tick("post_rst");

    // 2: streaming, one word per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      in_pc    = 32'(4 * i);
      tick("stream");
      chk("stream.data", out_data, 32'hA0 + 32'(i));
      chk("stream.pc",   out_pc,   32'(4 * i));
    end
    in_valid = 1'b0;
    tick("stream_end");

    // 3: backpressure fills the skid
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB0; in_pc = 32'h40;
    tick("bp0");
    in_data   = 32'hB1; in_pc = 32'h44;
    tick("bp1");
    chk("bp.in_ready_low", 32'(in_ready), 32'h0);
    in_data   = 32'hB2; in_pc = 32'h48;
    tick("bp2");
    tick("bp3");
    chk("bp.stall3", 32'(stall_cnt), 32'h3);
    chk("bp.head", out_data, 32'hB0);
    out_ready = 1'b1;
    tick("bp_drain0");
    chk("bp.second", out_data, 32'hB1);
    tick("bp_drain1");
    chk("bp.third", out_data, 32'hB2);
    in_valid = 1'b0;
    tick("bp_drain2");
    tick("bp_drain3");

    // 4: flush with both slots full and a coincident offer
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hC0; in_pc = 32'h80;
    tick("fl0");
    in_data   = 32'hC1; in_pc = 32'h84;
    tick("fl1");
    in_data   = 32'hC2; in_pc = 32'h88;
    flush     = 1'b1;
    tick("fl_edge");
    chk("fl.out_valid", 32'(out_valid), 32'h0);
    chk("fl.out_data",  out_data,       NOP);
    chk("fl.in_ready",  32'(in_ready),  32'h1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick("fl_after");

    // 5: stall counter saturation
    do_reset();
    in_valid  = 1'b1;
    in_data   = 32'hD0; in_pc = 32'hC0;
    out_ready = 1'b0;
    tick("sat_load");
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick("sat");
    chk("sat.stall", 32'(stall_cnt), 32'd15);

    // 6: random traffic
    do_reset();
    for (int i = 0; i < 10000; i++) rand_cycle("rand");
    idle_inputs();
    out_ready = 1'b1;
    tick("rand_drain0");
    tick("rand_drain1");
    tick("rand_drain2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
